// File: rtl/mem_port_arbiter.sv
// Three-requester arbiter for a single-port, fixed-latency synchronous word memory.
// Fixed priority dbg > dm > if, with a starvation override that forces a fetch grant.
module mem_port_arbiter #(
  parameter int unsigned AW         = 10,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [31:0]   dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [31:0]   dbg_addr,
  input  logic [31:0]   dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [31:0]   rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  localparam int unsigned SW = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;
  typedef enum logic [1:0] {OwnNone, OwnIf, OwnDm, OwnDbg} owner_e;

  state_e          r_state, w_state_d;
  owner_e          r_owner, w_owner_d;
  logic            r_we, w_we_d;
  logic [AW-1:0]   r_addr, w_addr_d;
  logic [31:0]     r_wdata, w_wdata_d;
  logic [3:0]      r_lat_cnt, w_lat_cnt_d;
  logic [SW-1:0]   r_starve_cnt, w_starve_cnt_d;
  logic [31:0]     r_rdata, w_rdata_d;
  logic            r_if_rvalid, w_if_rvalid_d;
  logic            r_dm_rvalid, w_dm_rvalid_d;
  logic            r_dbg_rvalid, w_dbg_rvalid_d;

  logic w_idle;
  logic w_force;
  logic w_unused;

  // Grants are combinational; gating with rstn keeps them low while reset is held.
  assign w_idle  = rstn && (r_state == StIdle);
  assign w_force = if_req && (r_starve_cnt == SW'(STARVE_LIM));

  assign dbg_gnt = w_idle && dbg_req && !w_force;
  assign dm_gnt  = w_idle && dm_req && !dbg_req && !w_force;
  assign if_gnt  = w_idle && if_req && (w_force || (!dbg_req && !dm_req));

  assign mem_en     = (r_state == StAccess);
  assign mem_we     = mem_en && r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign busy       = (r_state != StIdle);
  assign rdata      = r_rdata;
  assign if_rvalid  = r_if_rvalid;
  assign dm_rvalid  = r_dm_rvalid;
  assign dbg_rvalid = r_dbg_rvalid;

  assign w_unused = ^{if_addr[31:AW+2], if_addr[1:0], dm_addr[31:AW+2], dm_addr[1:0],
                      dbg_addr[31:AW+2], dbg_addr[1:0]};

  always_comb begin
    if (!if_req || if_gnt) begin
      w_starve_cnt_d = '0;
    end else if (r_starve_cnt == SW'(STARVE_LIM)) begin
      w_starve_cnt_d = r_starve_cnt;
    end else begin
      w_starve_cnt_d = r_starve_cnt + SW'(1);
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_owner_d      = r_owner;
    w_we_d         = r_we;
    w_addr_d       = r_addr;
    w_wdata_d      = r_wdata;
    w_lat_cnt_d    = r_lat_cnt;
    w_rdata_d      = r_rdata;
    w_if_rvalid_d  = 1'b0;
    w_dm_rvalid_d  = 1'b0;
    w_dbg_rvalid_d = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (dbg_gnt || dm_gnt || if_gnt) begin
          w_state_d   = StAccess;
          w_lat_cnt_d = 4'(LATENCY - 1);
        end
        if (dbg_gnt) begin
          w_owner_d = OwnDbg;
          w_we_d    = dbg_we;
          w_addr_d  = dbg_addr[AW+1:2];
          w_wdata_d = dbg_wdata;
        end else if (dm_gnt) begin
          w_owner_d = OwnDm;
          w_we_d    = dm_we;
          w_addr_d  = dm_addr[AW+1:2];
          w_wdata_d = dm_wdata;
        end else if (if_gnt) begin
          w_owner_d = OwnIf;
          w_we_d    = 1'b0;
          w_addr_d  = if_addr[AW+1:2];
          w_wdata_d = '0;
        end
      end
      StAccess: begin
        if (r_lat_cnt == 4'd0) begin
          w_rdata_d      = r_we ? 32'd0 : mem_rdata;
          w_if_rvalid_d  = (r_owner == OwnIf);
          w_dm_rvalid_d  = (r_owner == OwnDm);
          w_dbg_rvalid_d = (r_owner == OwnDbg);
          w_state_d      = StResp;
        end else begin
          w_lat_cnt_d = r_lat_cnt - 4'd1;
        end
      end
      StResp: begin
        w_state_d = StIdle;
        w_owner_d = OwnNone;
      end
      default: begin
        w_state_d = StIdle;
        w_owner_d = OwnNone;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= StIdle;
      r_owner      <= OwnNone;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      r_rdata      <= '0;
      r_if_rvalid  <= 1'b0;
      r_dm_rvalid  <= 1'b0;
      r_dbg_rvalid <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_owner      <= w_owner_d;
      r_we         <= w_we_d;
      r_addr       <= w_addr_d;
      r_wdata      <= w_wdata_d;
      r_lat_cnt    <= w_lat_cnt_d;
      r_starve_cnt <= w_starve_cnt_d;
      r_rdata      <= w_rdata_d;
      r_if_rvalid  <= w_if_rvalid_d;
      r_dm_rvalid  <= w_dm_rvalid_d;
      r_dbg_rvalid <= w_dbg_rvalid_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a cycle-arithmetic transaction model checks every
// output each cycle, and directed sequences pin the model with hand-computed values.
module tb_mem_port_arbiter;

  localparam int AW  = 10;
  localparam int LAT = 3;
  localparam int LIM = 4;

  logic          clk;
  logic          rstn;
  logic          if_req, dm_req, dbg_req, dm_we, dbg_we;
  logic [31:0]   if_addr, dm_addr, dm_wdata, dbg_addr, dbg_wdata;
  logic          if_gnt, dm_gnt, dbg_gnt, if_rvalid, dm_rvalid, dbg_rvalid;
  logic [31:0]   rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem_arr [0:1023];
  int          en_cnt;

  mem_port_arbiter #(.AW(AW), .LATENCY(LAT), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 + 32'(i * 17);
  endfunction

  // Memory: read data is only meaningful once mem_en has been held LAT cycles.
  assign mem_rdata = (en_cnt >= LAT - 1) ? mem_arr[mem_addr] : 32'hBAD0_BAD0;

  initial begin
    for (int i = 0; i < 1024; i++) mem_arr[i] <= init_word(i);
    en_cnt <= 0;
    forever begin
      @(posedge clk);
      if (mem_en && mem_we) mem_arr[mem_addr] <= mem_wdata;
      en_cnt <= mem_en ? en_cnt + 1 : 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, 32'(act), 32'(exp));
  endtask

  // Reference model: one outstanding access described by its grant cycle.
  logic [31:0] m_mem [0:1023];
  int          cyc, m_g, m_next, m_starve, m_who, win, idx;
  logic        m_valid, m_we, in_acc, resp;
  logic [31:0] m_addr, m_wdata, m_data, m_rdata;

  initial begin
    for (int i = 0; i < 1024; i++) m_mem[i] = init_word(i);
    cyc = 0; m_g = 0; m_next = 0; m_starve = 0; m_who = 0; m_valid = 1'b0;
    m_we = 1'b0; m_addr = '0; m_wdata = '0; m_data = '0; m_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        chk("rst_ctrl", 32'({if_gnt, dm_gnt, dbg_gnt, if_rvalid, dm_rvalid, dbg_rvalid,
                             mem_en, mem_we, busy, mem_addr}), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        m_valid = 1'b0; m_next = cyc; m_starve = 0; m_rdata = '0;
      end else begin
        win = 0;
        if (cyc >= m_next) begin
          if (if_req && m_starve == LIM) win = 1;
          else if (dbg_req) win = 3;
          else if (dm_req) win = 2;
          else if (if_req) win = 1;
        end
        chk1("if_gnt", if_gnt, win == 1);
        chk1("dm_gnt", dm_gnt, win == 2);
        chk1("dbg_gnt", dbg_gnt, win == 3);
        in_acc = m_valid && cyc > m_g && cyc <= m_g + LAT;
        resp   = m_valid && cyc == m_g + LAT + 1;
        if (resp) m_rdata = m_data;
        chk1("mem_en", mem_en, in_acc);
        chk1("mem_we", mem_we, in_acc && m_we);
        if (in_acc) chk("mem_addr", 32'(mem_addr), (m_addr >> 2) & 32'h3FF);
        if (in_acc && m_we) chk("mem_wdata", mem_wdata, m_wdata);
        chk1("if_rvalid", if_rvalid, resp && m_who == 1);
        chk1("dm_rvalid", dm_rvalid, resp && m_who == 2);
        chk1("dbg_rvalid", dbg_rvalid, resp && m_who == 3);
        chk("rdata", rdata, m_rdata);
        chk1("busy", busy, in_acc || resp);
        if (!if_req || win == 1) m_starve = 0;
        else if (m_starve < LIM) m_starve++;
        if (win != 0) begin
          m_who = win; m_valid = 1'b1; m_g = cyc; m_next = cyc + LAT + 2;
          case (win)
            1:       begin m_we = 1'b0;   m_addr = if_addr;  m_wdata = '0;        end
            2:       begin m_we = dm_we;  m_addr = dm_addr;  m_wdata = dm_wdata;  end
            default: begin m_we = dbg_we; m_addr = dbg_addr; m_wdata = dbg_wdata; end
          endcase
          idx = int'((m_addr >> 2) & 32'h3FF);
          m_data = m_we ? 32'd0 : m_mem[idx];
          if (m_we) m_mem[idx] = m_wdata;
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_reqs();
    if_req = 1'b0; dm_req = 1'b0; dbg_req = 1'b0;
  endtask

  // who: 0 fetch, 1 load/store, 2 debug. Expects grant now, rvalid LAT+1 cycles later.
  task automatic dir_access(input int who, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_maddr,
                            input logic [31:0] exp_rdata);
    logic g, v;
    case (who)
      0:       begin if_req = 1'b1; if_addr = addr; end
      1:       begin dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata; end
      default: begin dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; end
    endcase
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      g = (who == 0) ? if_gnt : (who == 1) ? dm_gnt : dbg_gnt;
      v = (who == 0) ? if_rvalid : (who == 1) ? dm_rvalid : dbg_rvalid;
      chk1("dir_gnt", g, k == 0);
      chk1("dir_mem_en", mem_en, k >= 1 && k <= LAT);
      chk1("dir_rvalid", v, k == LAT + 1);
      if (k == 1) begin
        chk("dir_mem_addr", 32'(mem_addr), exp_maddr);
        chk1("dir_mem_we", mem_we, we);
      end
      if (k == LAT + 1) chk("dir_rdata", rdata, exp_rdata);
      tick();
      if (k == 0) clr_reqs();
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] r;
    r = $urandom;
    r = (r & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
    return r;
  endfunction

  int g_dbg, g_dm, g_if;

  initial begin
    rstn = 1'b0;
    clr_reqs();
    dm_we = 1'b0; dbg_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; dbg_addr = '0; dbg_wdata = '0;
    #1;
    repeat (3) tick();
    rstn = 1'b1;
    repeat (2) tick();

    dir_access(0, 1'b0, 32'h1C00_0008, 32'd0, 32'd2, 32'hA500_0022);
    dir_access(1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h10, 32'd0);
    dir_access(2, 1'b0, 32'h0000_0040, 32'd0, 32'h10, 32'hDEAD_BEEF);
    dir_access(2, 1'b0, 32'h0000_1000, 32'd0, 32'd0, 32'hA500_0000);

    // Contention: fetch starves for LIM cycles and overtakes dm at the second grant slot.
    repeat (2) tick();
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h8;
    dm_req = 1'b1;  dm_we = 1'b0;  dm_addr = 32'hC;
    if_req = 1'b1;  if_addr = 32'h4;
    g_dbg = -1; g_dm = -1; g_if = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      #1;
      if (dbg_gnt) g_dbg = k;
      if (dm_gnt) g_dm = k;
      if (if_gnt) g_if = k;
      tick();
      if (g_dbg == k) dbg_req = 1'b0;
      if (g_dm == k) dm_req = 1'b0;
      if (g_if == k) if_req = 1'b0;
    end
    clr_reqs();
    chk("cont_dbg_cycle", 32'(g_dbg), 32'd0);
    chk("cont_if_cycle", 32'(g_if), 32'(LAT + 2));
    chk("cont_dm_cycle", 32'(g_dm), 32'(2 * (LAT + 2)));
    repeat (3) tick();

    // Abort: reset during ACCESS, then a fetch pending across reset is served.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
    @(negedge clk);
    #1;
    chk1("abort_gnt", dm_gnt, 1'b1);
    tick();
    clr_reqs();
    if_req = 1'b1; if_addr = 32'h44;
    rstn = 1'b0;
    @(negedge clk);
    chk1("abort_mem_en", mem_en, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    tick();
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk1("abort_if_gnt", if_gnt, k == 0);
      chk1("abort_dm_rvalid", dm_rvalid, 1'b0);
      chk1("abort_if_rvalid", if_rvalid, k == LAT + 1);
      if (k == LAT + 1) chk("abort_rdata", rdata, 32'hA500_0121);
      tick();
      if (k == 0) clr_reqs();
    end

    // Randomized traffic with frequent dm contention to exercise starvation.
    for (int c = 0; c < 3000; c++) begin
      dbg_req   = ($urandom_range(0, 7) == 0);
      dm_req    = ($urandom_range(0, 2) != 0);
      if_req    = ($urandom_range(0, 3) != 0);
      dm_we     = $urandom_range(0, 1) == 1;
      dbg_we    = $urandom_range(0, 1) == 1;
      if_addr   = rnd_addr();
      dm_addr   = rnd_addr();
      dbg_addr  = rnd_addr();
      dm_wdata  = $urandom;
      dbg_wdata = $urandom;
      tick();
    end
    clr_reqs();
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
